// File: rtl/router13_pkg.sv
// Shared constants and state encoding for the router input-path controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package router13_pkg;

    // Controller states, binary encoded in 4 bits.
    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        WAIT_TILL_EMPTY    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    // Header address value that selects no FIFO; such packets are dropped.
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    // Number of output FIFOs behind the router.
    localparam int NUM_FIFOS = 3;

    // Pick the per-FIFO flag for an address; the invalid address maps to 0
    // so a dropped packet can never see an empty flag or a soft reset.
    function automatic logic fifo_sel(input logic [NUM_FIFOS-1:0] flags,
                                      input logic [1:0]           addr);
        logic bit_sel;
        case (addr)
            2'd0:    bit_sel = flags[0];
            2'd1:    bit_sel = flags[1];
            2'd2:    bit_sel = flags[2];
            default: bit_sel = 1'b0;
        endcase
        return bit_sel;
    endfunction

endpackage

// File: rtl/router_fsm13.sv
// Packet controller: sequences header, payload, full-stall and parity handling.
// Latency: Moore outputs, one cycle from input change to output change.
// Backpressure: busy holds the source; fifofull stalls in FIFO_FULL_STATE.
module router_fsm13
    import router13_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pktvalid,
    input  logic [1:0] datain,
    input  logic       fifofull,
    input  logic [2:0] fifoempty,
    input  logic [2:0] softreset,
    input  logic       paritydone,
    input  logic       lowpktvalid,
    output logic       detectadd,
    output logic       lfdstate,
    output logic       ldstate,
    output logic       fullstate,
    output logic       lafstate,
    output logic       rstintreg,
    output logic       writeenbreg,
    output logic       busy,
    output logic [1:0] dest
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] dest_q;
    logic       dest_soft;   // soft reset of the FIFO this packet targets
    logic       hdr_empty;   // empty flag of the FIFO named by the header
    logic       dest_empty;  // empty flag of the latched destination

    assign dest_soft  = fifo_sel(softreset, dest_q);
    assign hdr_empty  = fifo_sel(fifoempty, datain);
    assign dest_empty = fifo_sel(fifoempty, dest_q);

    // State register; asynchronous reset returns to address decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
        end else begin
            state_q <= state_d;
        end
    end

    // Destination latch: captured on the header byte, held for the packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_q <= 2'd0;
        end else if (state_q == DECODE_ADDRESS && pktvalid) begin
            dest_q <= datain;
        end
    end

    // Next-state logic; a soft reset of the selected FIFO overrides the table.
    always_comb begin
        state_d = state_q;
        if (state_q != DECODE_ADDRESS && dest_soft) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pktvalid) begin
                        if (datain == ADDR_INVALID) begin
                            state_d = DROP_PACKET;
                        end else if (hdr_empty) begin
                            state_d = LOAD_FIRST_DATA;
                        end else begin
                            state_d = WAIT_TILL_EMPTY;
                        end
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (dest_empty) begin
                        state_d = LOAD_FIRST_DATA;
                    end
                end
                LOAD_FIRST_DATA: begin
                    state_d = LOAD_DATA;
                end
                LOAD_DATA: begin
                    // A full FIFO takes precedence over the end of payload.
                    if (fifofull) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pktvalid) begin
                        state_d = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifofull) begin
                        state_d = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (paritydone) begin
                        state_d = DECODE_ADDRESS;
                    end else if (lowpktvalid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: begin
                    state_d = CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR: begin
                    if (fifofull) begin
                        state_d = FIFO_FULL_STATE;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                DROP_PACKET: begin
                    if (!pktvalid) begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                default: begin
                    state_d = DECODE_ADDRESS;
                end
            endcase
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        detectadd   = (state_q == DECODE_ADDRESS);
        lfdstate    = (state_q == LOAD_FIRST_DATA);
        ldstate     = (state_q == LOAD_DATA);
        fullstate   = (state_q == FIFO_FULL_STATE);
        lafstate    = (state_q == LOAD_AFTER_FULL);
        rstintreg   = (state_q == CHECK_PARITY_ERROR);
        writeenbreg = (state_q == LOAD_DATA)   ||
                      (state_q == LOAD_PARITY) ||
                      (state_q == LOAD_AFTER_FULL);
        busy        = !((state_q == DECODE_ADDRESS) ||
                        (state_q == LOAD_DATA)      ||
                        (state_q == DROP_PACKET));
        dest        = dest_q;
    end

endmodule

// File: tb/tb_router_fsm13.sv
// Directed self-checking bench for the router packet controller.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: busy/fifofull behaviour covered by directed scenarios.
module tb_router_fsm13;

    logic       clk = 1'b0;
    logic       reset;
    logic       pktvalid;
    logic [1:0] datain;
    logic       fifofull;
    logic [2:0] fifoempty;
    logic [2:0] softreset;
    logic       paritydone;
    logic       lowpktvalid;
    logic       detectadd, lfdstate, ldstate, fullstate, lafstate;
    logic       rstintreg, writeenbreg, busy;
    logic [1:0] dest;

    int compared = 0;
    int mismatched = 0;

    // Output vector: {detectadd,lfd,ld,full,laf,rstint,writeenb,busy}
    logic [7:0] obs;
    assign obs = {detectadd, lfdstate, ldstate, fullstate, lafstate,
                  rstintreg, writeenbreg, busy};

    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0010;
    localparam logic [7:0] O_FULL = 8'b0001_0001;
    localparam logic [7:0] O_LAF  = 8'b0000_1011;
    localparam logic [7:0] O_LP   = 8'b0000_0011;
    localparam logic [7:0] O_CPE  = 8'b0000_0101;
    localparam logic [7:0] O_DROP = 8'b0000_0000;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;

    router_fsm13 dut (
        .clk         (clk),
        .reset       (reset),
        .pktvalid    (pktvalid),
        .datain      (datain),
        .fifofull    (fifofull),
        .fifoempty   (fifoempty),
        .softreset   (softreset),
        .paritydone  (paritydone),
        .lowpktvalid (lowpktvalid),
        .detectadd   (detectadd),
        .lfdstate    (lfdstate),
        .ldstate     (ldstate),
        .fullstate   (fullstate),
        .lafstate    (lafstate),
        .rstintreg   (rstintreg),
        .writeenbreg (writeenbreg),
        .busy        (busy),
        .dest        (dest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pktvalid    = 1'b0;
        datain      = 2'd0;
        fifofull    = 1'b0;
        fifoempty   = 3'b111;
        softreset   = 3'b000;
        paritydone  = 1'b0;
        lowpktvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        compared++;
        if (obs !== O_DA) begin
            mismatched++;
            $display("FAIL reset_outputs got=%b want=%b", obs, O_DA);
        end
        compared++;
        if (dest !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_dest got=%0d want=0", dest);
        end
        reset = 1'b0;
        tick();
        compared++;
        if (obs !== O_DA) begin
            mismatched++;
            $display("FAIL reset_idle_stay got=%b want=%b", obs, O_DA);
        end
    endtask

    // Header addr 2, three payload bytes, parity.
    task automatic test_packet();
        logic [7:0] want [7];
        int         we_cnt;
        want = '{O_LFD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
        we_cnt = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            // header + 3 payload edges with pktvalid, then parity byte
            pktvalid = (i < 4);
            datain   = (i == 0) ? 2'd2 : 2'(i);
            tick();
            if (writeenbreg === 1'b1) we_cnt++;
            compared++;
            if (obs !== want[i]) begin
                mismatched++;
                $display("FAIL packet_step%0d got=%b want=%b", i, obs, want[i]);
            end
        end
        compared++;
        if (dest !== 2'd2) begin
            mismatched++;
            $display("FAIL packet_dest got=%0d want=2", dest);
        end
        compared++;
        if (we_cnt != 4) begin
            mismatched++;
            $display("FAIL packet_we_cycles got=%0d want=4", we_cnt);
        end
    endtask

    // Reset asserted asynchronously while in LOAD_DATA.
    task automatic test_reset_mid();
        do_reset();
        pktvalid = 1'b1;
        datain   = 2'd2;
        tick();
        tick();
        compared++;
        if (obs !== O_LD) begin
            mismatched++;
            $display("FAIL rstmid_setup got=%b want=%b", obs, O_LD);
        end
        reset = 1'b1;
        #2;
        compared++;
        if ({detectadd, busy, dest} !== 4'b1000) begin
            mismatched++;
            $display("FAIL rstmid_async got=%b want=1000", {detectadd, busy, dest});
        end
        tick();
        reset = 1'b0;
        idle_inputs();
    endtask

    // Busy FIFO wait, then full-stall sequence and return to LOAD_DATA.
    task automatic test_wait_and_full();
        do_reset();
        fifoempty = 3'b101;
        pktvalid  = 1'b1;
        datain    = 2'd1;
        tick();
        compared++;
        if (obs !== O_WTE) begin
            mismatched++;
            $display("FAIL wte_enter got=%b want=%b", obs, O_WTE);
        end
        datain = 2'd0;
        tick();
        compared++;
        if (obs !== O_WTE) begin
            mismatched++;
            $display("FAIL wte_hold got=%b want=%b", obs, O_WTE);
        end
        fifoempty = 3'b010;
        tick();
        compared++;
        if (obs !== O_LFD) begin
            mismatched++;
            $display("FAIL wte_exit got=%b want=%b", obs, O_LFD);
        end
        tick();
        compared++;
        if (obs !== O_LD) begin
            mismatched++;
            $display("FAIL full_pre got=%b want=%b", obs, O_LD);
        end
        fifofull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (obs !== O_FULL) begin
                mismatched++;
                $display("FAIL full_hold%0d got=%b want=%b", i, obs, O_FULL);
            end
        end
        fifofull = 1'b0;
        tick();
        compared++;
        if (obs !== O_LAF) begin
            mismatched++;
            $display("FAIL full_laf got=%b want=%b", obs, O_LAF);
        end
        tick();
        compared++;
        if (obs !== O_LD) begin
            mismatched++;
            $display("FAIL laf_to_ld got=%b want=%b", obs, O_LD);
        end
    endtask

    // LAF exits via lowpktvalid and paritydone; CPE re-entering full; fifofull priority.
    task automatic test_parity_paths();
        do_reset();
        pktvalid = 1'b1;
        datain   = 2'd0;
        tick();
        tick();
        // pktvalid falls together with fifofull rising: full wins
        pktvalid = 1'b0;
        fifofull = 1'b1;
        tick();
        compared++;
        if (obs !== O_FULL) begin
            mismatched++;
            $display("FAIL full_priority got=%b want=%b", obs, O_FULL);
        end
        fifofull    = 1'b0;
        tick();
        lowpktvalid = 1'b1;
        tick();
        compared++;
        if (obs !== O_LP) begin
            mismatched++;
            $display("FAIL laf_to_lp got=%b want=%b", obs, O_LP);
        end
        lowpktvalid = 1'b0;
        tick();
        fifofull = 1'b1;
        tick();
        compared++;
        if (obs !== O_FULL) begin
            mismatched++;
            $display("FAIL cpe_to_full got=%b want=%b", obs, O_FULL);
        end
        fifofull = 1'b0;
        tick();
        paritydone = 1'b1;
        tick();
        compared++;
        if (obs !== O_DA) begin
            mismatched++;
            $display("FAIL laf_to_da got=%b want=%b", obs, O_DA);
        end
        paritydone = 1'b0;
    endtask

    // Invalid address: packet dropped, no writes, source not stalled.
    task automatic test_drop();
        do_reset();
        pktvalid = 1'b1;
        datain   = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            datain = 2'(i);
            compared++;
            if (obs !== O_DROP) begin
                mismatched++;
                $display("FAIL drop_step%0d got=%b want=%b", i, obs, O_DROP);
            end
        end
        compared++;
        if (dest !== 2'd3) begin
            mismatched++;
            $display("FAIL drop_dest got=%0d want=3", dest);
        end
        pktvalid = 1'b0;
        tick();
        compared++;
        if (obs !== O_DA) begin
            mismatched++;
            $display("FAIL drop_exit got=%b want=%b", obs, O_DA);
        end
    endtask

    // Soft reset of the selected FIFO aborts; other FIFOs are ignored.
    task automatic test_softreset();
        do_reset();
        pktvalid = 1'b1;
        datain   = 2'd0;
        tick();
        tick();
        fifofull = 1'b1;
        tick();
        softreset = 3'b100;
        tick();
        compared++;
        if (obs !== O_FULL) begin
            mismatched++;
            $display("FAIL soft_other got=%b want=%b", obs, O_FULL);
        end
        softreset = 3'b001;
        tick();
        compared++;
        if (obs !== O_DA) begin
            mismatched++;
            $display("FAIL soft_sel got=%b want=%b", obs, O_DA);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_packet();
        test_reset_mid();
        test_wait_and_full();
        test_parity_paths();
        test_drop();
        test_softreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
